alu_exec_seq: RTL and testbench



---
 rtl/alu_exec_pkg.sv | 31 +++
 rtl/alu_iter_shifter.sv | 63 ++++++
 rtl/alu_exec_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_exec_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: control-vector bit indices, FSM states, shift kinds.
// The optional barrel-shifter build (ALU_FASTSHIFT_EN) uses the same definitions.
package alu_exec_pkg;

  localparam int CTRL_W    = 26;
  localparam int OP_ADD    = 0;
  localparam int OP_SUB    = 1;
  localparam int OP_AND    = 2;
  localparam int OP_OR     = 3;
  localparam int OP_XOR    = 4;
  localparam int OP_NOR    = 5;
  localparam int OP_SLT    = 6;
  localparam int OP_SLTU   = 7;
  localparam int OP_SLL    = 8;
  localparam int OP_SRL    = 9;
  localparam int OP_SRA    = 10;
  localparam int OP_PASSB  = 11;
  localparam int CTRL_RSVD = 23;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2
  } shift_kind_e;

endpackage

// File: rtl/alu_iter_shifter.sv
// One-bit-per-cycle shifter: accumulator plus down-counter with start/done handshake.
// Not instantiated when ALU_FASTSHIFT_EN is defined.
module alu_iter_shifter
  import alu_exec_pkg::*;
#(
  parameter int  WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  shift_kind_e        kind,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] amount,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  shift_kind_e        kind_q, kind_d;
  logic [WIDTH-1:0]   acc_shifted;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input shift_kind_e k);
    case (k)
      SLL:     return {v[WIDTH-2:0], 1'b0};
      SRL:     return {1'b0, v[WIDTH-1:1]};
      default: return {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  assign acc_shifted = shift1(acc_q, kind_q);
  // The final shift is taken combinationally so the result is ready on the count-1 cycle.
  assign done        = (cnt_q == SHAMT_W'(1));
  assign result      = acc_shifted;

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (start) begin
      acc_d  = data_in;
      cnt_d  = amount;
      kind_d = kind;
    end else if (cnt_q != '0) begin
      acc_d = acc_shifted;
      cnt_d = cnt_q - SHAMT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kind_q <= SLL;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// ALU execute stage: one-hot control vector in, registered result out over valid/ready.
// ALU_FASTSHIFT_EN selects a single-cycle barrel shifter instead of the iterative one.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int  WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_vec,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_zero,
  output logic              out_illegal,
  output logic              busy
);

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_zero_q, out_zero_d;
  logic               out_illegal_q, out_illegal_d;
  logic [3:0]         op_sel;
  logic               op_hit;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   imm_res;
  logic               accept;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic               load_ill;
  logic               unused_ctrl;

  // Upper control lines (including the reserved bit) carry no operation here.
  assign unused_ctrl = ^ctrl_vec[CTRL_W-1:OP_PASSB+1];
  assign shamt       = op_b[SHAMT_W-1:0];
  assign accept      = in_valid && in_ready;

  always_comb begin
    op_sel = '0;
    op_hit = 1'b0;
    for (int i = OP_PASSB; i >= 0; i--) begin
      if (ctrl_vec[i]) begin
        op_sel = 4'(i);
        op_hit = 1'b1;
      end
    end
  end

  always_comb begin
    imm_res = '0;
    if (op_hit) begin
      case (op_sel)
        4'(OP_ADD):  imm_res = op_a + op_b;
        4'(OP_SUB):  imm_res = op_a - op_b;
        4'(OP_AND):  imm_res = op_a & op_b;
        4'(OP_OR):   imm_res = op_a | op_b;
        4'(OP_XOR):  imm_res = op_a ^ op_b;
        4'(OP_NOR):  imm_res = ~(op_a | op_b);
        4'(OP_SLT):  imm_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        4'(OP_SLTU): imm_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
`ifdef ALU_FASTSHIFT_EN
        4'(OP_SLL):  imm_res = op_a << shamt;
        4'(OP_SRL):  imm_res = op_a >> shamt;
        4'(OP_SRA):  imm_res = WIDTH'($signed(op_a) >>> shamt);
`else
        // Only reached for a zero shift amount; nonzero amounts take the iterative path.
        4'(OP_SLL), 4'(OP_SRL), 4'(OP_SRA): imm_res = op_a;
`endif
        4'(OP_PASSB): imm_res = op_b;
        default:      imm_res = '0;
      endcase
    end
  end

`ifdef ALU_FASTSHIFT_EN

  assign in_ready = !out_valid_q || out_ready;
  assign busy     = 1'b0;

  always_comb begin
    load     = accept;
    load_val = imm_res;
    load_ill = !op_hit;
  end

`else

  state_e      state_q, state_d;
  logic        is_shift;
  shift_kind_e sh_kind;
  logic        sh_start;
  logic        sh_done;
  logic [WIDTH-1:0] sh_res;

  assign is_shift = op_hit && (op_sel >= 4'(OP_SLL)) && (op_sel <= 4'(OP_SRA));
  assign sh_kind  = (op_sel == 4'(OP_SLL)) ? SLL :
                    (op_sel == 4'(OP_SRL)) ? SRL : SRA;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q != IDLE);

  alu_iter_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (sh_start),
    .kind    (sh_kind),
    .data_in (op_a),
    .amount  (shamt),
    .done    (sh_done),
    .result  (sh_res)
  );

  always_comb begin
    state_d  = state_q;
    sh_start = 1'b0;
    load     = 1'b0;
    load_val = imm_res;
    load_ill = !op_hit;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            sh_start = 1'b1;
            state_d  = SHIFT;
          end else begin
            load = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (sh_done) begin
          load     = 1'b1;
          load_val = sh_res;
          load_ill = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`endif

  always_comb begin
    out_valid_d   = out_valid_q && !out_ready;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_illegal_d = out_illegal_q;
    if (load) begin
      out_valid_d   = 1'b1;
      out_result_d  = load_val;
      out_zero_d    = (load_val == '0);
      out_illegal_d = load_ill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Scoreboard bench for alu_exec_seq: stimulus pushes expected results, a negedge monitor pops them.
// Shift-latency expectations follow ALU_FASTSHIFT_EN when it is defined for the build.
module tb_alu_exec_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] ctrl_vec;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;
  logic        busy;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_exec_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ctrl_vec    (ctrl_vec),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h required no transfer", out_result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", out_result, e.result);
        chk("zero", 32'(out_zero), 32'(e.zero));
        chk("illegal", 32'(out_illegal), 32'(e.illegal));
      end
    end
  end

  // Returns 1 ns after the accepting edge.
  task automatic issue(input logic [25:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic il, input bit push);
    int n;
    in_valid = 1'b1;
    ctrl_vec = c;
    op_a     = a;
    op_b     = b;
    if (push) exp_q.push_back('{result: r, zero: (r == 32'd0), illegal: il});
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctrl_vec = '0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    ctrl_vec  = '0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD wraps to zero; result visible one edge after accept
    issue(26'd1 << 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    @(negedge clk);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Priority, illegal encodings and the remaining single-cycle ops
    issue((26'd1 << 2) | (26'd1 << 4), 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
    issue(26'd1 << 23, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1);
    issue(26'd0, 32'h5, 32'h5, 32'd0, 1'b1, 1);
    issue(26'd1 << 12, 32'h5, 32'h5, 32'd0, 1'b1, 1);
    issue(26'd1 << 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    issue(26'd1 << 3, 32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 1'b0, 1);
    issue(26'd1 << 4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1);
    issue(26'd1 << 5, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0, 1);
    issue(26'd1 << 6, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
    issue(26'd1 << 7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
    issue((26'd1 << 11) | (26'd1 << 12), 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1);
    issue(26'd1 << 8, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    issue(26'd1 << 8, 32'd3, 32'h21, 32'd6, 1'b0, 1);
    issue(26'd1 << 9, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1);
    issue(26'd1 << 8, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1);

    // SRA by 4: stalls input for 4 cycles in the iterative build
    issue(26'd1 << 10, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
`ifdef ALU_FASTSHIFT_EN
    @(negedge clk);
    chk("sra_fast_valid", 32'(out_valid), 32'd1);
    chk("sra_fast_busy", 32'(busy), 32'd0);
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("sra_busy", 32'(busy), 32'd1);
      chk("sra_in_ready", 32'(in_ready), 32'd0);
      chk("sra_pending_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("sra_done_valid", 32'(out_valid), 32'd1);
    chk("sra_done_busy", 32'(busy), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Shift by zero behaves as a single-cycle op
    issue(26'd1 << 10, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1);
    @(negedge clk);
    chk("sra0_valid", 32'(out_valid), 32'd1);
    chk("sra0_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure then back-to-back drain and accept
    out_ready = 1'b0;
    issue(26'd1 << 1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result_held", out_result, 32'hFFFF_FFFE);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(26'd1 << 0, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_result", out_result, 32'd2);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift drops the pending result
`ifdef ALU_FASTSHIFT_EN
    issue(26'd1 << 8, 32'd1, 32'd20, 32'h0010_0000, 1'b0, 1);
`else
    issue(26'd1 << 8, 32'd1, 32'd20, 32'h0, 1'b0, 0);
`endif
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(26'd1 << 0, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    @(negedge clk);
    chk("post_rst_add_valid", 32'(out_valid), 32'd1);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    end
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
